// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: opcode/memory handshake in, datapath controls and status out
interface multicycle_control_fsm_if;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemToReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state;
    logic        retire;
    logic [31:0] instr_count;
    logic        illegal;
    modport master (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
        input  MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
        input  state, retire, instr_count, illegal
    );
    modport slave (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
        output MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
        output state, retire, instr_count, illegal
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle MIPS sequencer with retire counter and illegal-opcode trap
module multicycle_control_fsm (
    input logic clk,
    input logic reset,
    multicycle_control_fsm_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4,
        MEMWB = 4'd5, MEMWR = 4'd6, EXEC = 4'd7, RWB = 4'd8, BRANCH = 4'd9,
        ADDIEX = 4'd10, ADDIWB = 4'd11, JUMP = 4'd12, ILLEGAL = 4'd15
    } state_t;
    typedef struct packed {
        logic       pcw, pcwc, iord, memrd, memwr, m2r, regdst, regwr, srca;
        logic [1:0] srcb, aluop, pcsrc;
    } ctrl_t;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    state_t      st, nx;
    ctrl_t       c;
    logic        ret_q, ill, retire_w;
    logic [31:0] count;
    function automatic ctrl_t moore(state_t s);
        ctrl_t o;
        o = '0;
        case (s)
            FETCH:   begin o.memrd = 1'b1; o.srcb = 2'b01; end
            DECODE:  o.srcb = 2'b11;
            MEMADR:  begin o.srca = 1'b1; o.srcb = 2'b10; end
            MEMRD:   begin o.memrd = 1'b1; o.iord = 1'b1; end
            MEMWB:   begin o.regwr = 1'b1; o.m2r = 1'b1; end
            MEMWR:   begin o.memwr = 1'b1; o.iord = 1'b1; end
            EXEC:    begin o.srca = 1'b1; o.aluop = 2'b10; end
            RWB:     begin o.regwr = 1'b1; o.regdst = 1'b1; end
            BRANCH:  begin o.srca = 1'b1; o.aluop = 2'b01; o.pcwc = 1'b1; o.pcsrc = 2'b01; end
            ADDIEX:  begin o.srca = 1'b1; o.srcb = 2'b10; end
            ADDIWB:  o.regwr = 1'b1;
            JUMP:    begin o.pcw = 1'b1; o.pcsrc = 2'b10; end
            default: o = '0;
        endcase
        return o;
    endfunction
    always_comb begin
        nx = IDLE;
        case (st)
            IDLE:    nx = FETCH;
            FETCH:   nx = bus.mem_ready ? DECODE : FETCH;
            DECODE:
                case (bus.opcode)
                    OP_LW, OP_SW: nx = MEMADR;
                    OP_R:         nx = EXEC;
                    OP_BEQ:       nx = BRANCH;
                    OP_ADDI:      nx = ADDIEX;
                    OP_J:         nx = JUMP;
                    default:      nx = ILLEGAL;
                endcase
            MEMADR:  nx = bus.opcode == OP_SW ? MEMWR : MEMRD;
            MEMRD:   nx = bus.mem_ready ? MEMWB : MEMRD;
            MEMWR:   nx = bus.mem_ready ? FETCH : MEMWR;
            EXEC:    nx = RWB;
            ADDIEX:  nx = ADDIWB;
            MEMWB, RWB, BRANCH, ADDIWB, JUMP: nx = FETCH;
            ILLEGAL: nx = ILLEGAL;
            default: nx = IDLE;
        endcase
    end
    // a store retires on the cycle memory accepts it, so that term stays combinational
    assign retire_w = ret_q | (st == MEMWR && bus.mem_ready);
    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= IDLE;
            c     <= '0;
            ret_q <= 1'b0;
            ill   <= 1'b0;
            count <= '0;
        end else begin
            st    <= nx;
            c     <= moore(nx);
            ret_q <= nx inside {MEMWB, RWB, BRANCH, ADDIWB, JUMP};
            ill   <= ill | (nx == ILLEGAL);
            count <= count + 32'(retire_w);
        end
    end
    always_comb begin
        bus.PCWrite     = c.pcw | (st == FETCH && bus.mem_ready);
        bus.IRWrite     = st == FETCH && bus.mem_ready;
        bus.PCWriteCond = c.pcwc;
        bus.IorD        = c.iord;
        bus.MemRead     = c.memrd;
        bus.MemWrite    = c.memwr;
        bus.MemToReg    = c.m2r;
        bus.RegDst      = c.regdst;
        bus.RegWrite    = c.regwr;
        bus.ALUSrcA     = c.srca;
        bus.ALUSrcB     = c.srcb;
        bus.ALUOp       = c.aluop;
        bus.PCSource    = c.pcsrc;
        bus.state       = st;
        bus.retire      = retire_w;
        bus.instr_count = count;
        bus.illegal     = ill;
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: instruction-level model of the controller compared every cycle
module tb_multicycle_control_fsm;
    logic clk, reset;
    multicycle_control_fsm_if bus();
    multicycle_control_fsm dut (.clk(clk), .reset(reset), .bus(bus));
    initial clk = 1'b0;
    always #10 clk = ~clk;
    int n_checks = 0, n_fail = 0;
    int e_state, cur_len, last_len, irw_n, last_irw;
    logic e_mr, e_ret, e_valid;
    logic [31:0] e_cnt, m_cnt;
    logic [3:0] prev_st = 4'd0;
    logic [15:0] dut_ctrl;
    assign dut_ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                       bus.IRWrite, bus.MemToReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                       bus.ALUSrcB, bus.ALUOp, bus.PCSource};
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask
    // bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemToReg RegDst RegWrite ALUSrcA | ALUSrcB ALUOp PCSource
    function automatic logic [15:0] exp_ctrl(input int s, input logic mr);
        case (s)
            1:  return {mr, 2'b00, 1'b1, 1'b0, mr, 4'b0000, 6'b010000};
            2:  return 16'b0000000000_110000;
            3:  return 16'b0000000001_100000;
            4:  return 16'b0011000000_000000;
            5:  return 16'b0000001010_000000;
            6:  return 16'b0010100000_000000;
            7:  return 16'b0000000001_001000;
            8:  return 16'b0000000110_000000;
            9:  return 16'b0100000001_000101;
            10: return 16'b0000000001_100000;
            11: return 16'b0000000010_000000;
            12: return 16'b1000000000_000010;
            default: return 16'h0000;
        endcase
    endfunction
    always @(negedge clk) begin
        #2;
        if (e_valid) begin
            chk("state", 32'(bus.state), 32'(e_state));
            chk("controls", 32'(dut_ctrl), 32'(exp_ctrl(e_state, e_mr)));
            chk("retire", 32'(bus.retire), 32'(e_ret));
            chk("instr_count", bus.instr_count, e_cnt);
            chk("illegal", 32'(bus.illegal), 32'(e_state == 15));
        end
        if (bus.state == 4'd1 && prev_st != 4'd1) begin
            cur_len = 1;
            irw_n = 0;
        end else cur_len++;
        if (bus.IRWrite) irw_n++;
        if (bus.retire) begin
            last_len = cur_len;
            last_irw = irw_n;
        end
        prev_st = bus.state;
    end
    task automatic step(input logic rs, input logic mr, input int st, input logic last, input logic c);
        @(negedge clk);
        reset = rs;
        bus.mem_ready = mr;
        e_state = st;
        e_mr = mr;
        e_ret = last;
        e_cnt = m_cnt;
        e_valid = c;
        if (last) m_cnt++;
    endtask
    task automatic do_reset(input int n);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        m_cnt = 0;
        repeat (n - 1) step(1'b1, 1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 0, 1'b0, 1'b1);
    endtask
    // expands one instruction into its state path, with waits and the retire on its last cycle
    task automatic run(input logic [5:0] op, input int fw, input int mw, input logic ign);
        int sq[$];
        logic mq[$];
        logic legal;
        legal = op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        bus.opcode = op;
        repeat (fw) begin sq.push_back(1); mq.push_back(1'b0); end
        sq.push_back(1); mq.push_back(1'b1);
        sq.push_back(2); mq.push_back(ign);
        case (op)
            6'b000000: begin sq.push_back(7); mq.push_back(ign); sq.push_back(8); mq.push_back(ign); end
            6'b001000: begin sq.push_back(10); mq.push_back(ign); sq.push_back(11); mq.push_back(ign); end
            6'b100011: begin
                sq.push_back(3); mq.push_back(ign);
                repeat (mw) begin sq.push_back(4); mq.push_back(1'b0); end
                sq.push_back(4); mq.push_back(1'b1);
                sq.push_back(5); mq.push_back(ign);
            end
            6'b101011: begin
                sq.push_back(3); mq.push_back(ign);
                repeat (mw) begin sq.push_back(6); mq.push_back(1'b0); end
                sq.push_back(6); mq.push_back(1'b1);
            end
            6'b000100: begin sq.push_back(9); mq.push_back(ign); end
            6'b000010: begin sq.push_back(12); mq.push_back(ign); end
            default: repeat (10) begin sq.push_back(15); mq.push_back(ign); end
        endcase
        foreach (sq[i]) step(1'b0, mq[i], sq[i], legal && i == sq.size() - 1, 1'b1);
    endtask
    initial begin
        reset = 1'b1;
        bus.opcode = 6'b000000;
        bus.mem_ready = 1'b0;
        e_valid = 1'b0;
        m_cnt = 0;
        do_reset(3);
        run(6'b000000, 0, 0, 1'b1);
        #12;
        chk("rtype_len", 32'(last_len), 32'd4);
        chk("rtype_count", bus.instr_count, 32'd1);
        run(6'b100011, 2, 1, 1'b1);
        #12;
        chk("lw_len", 32'(last_len), 32'd8);
        chk("lw_irwrite_pulses", 32'(last_irw), 32'd1);
        chk("lw_count", bus.instr_count, 32'd2);
        do_reset(2);
        run(6'b101011, 0, 0, 1'b1);
        #12 chk("sw_len", 32'(last_len), 32'd4);
        run(6'b000100, 0, 0, 1'b1);
        #12 chk("beq_len", 32'(last_len), 32'd3);
        run(6'b000010, 0, 0, 1'b1);
        #12;
        chk("j_len", 32'(last_len), 32'd3);
        chk("three_count", bus.instr_count, 32'd3);
        run(6'b111111, 0, 0, 1'b1);
        #12;
        chk("illegal_state", 32'(bus.state), 32'd15);
        chk("illegal_flag", 32'(bus.illegal), 32'd1);
        do_reset(2);
        #12 chk("illegal_cleared", 32'(bus.illegal), 32'd0);
        bus.opcode = 6'b100011;
        step(1'b0, 1'b1, 1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 2, 1'b0, 1'b1);
        step(1'b0, 1'b1, 3, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4, 1'b0, 1'b1);
        step(1'b1, 1'b0, 4, 1'b0, 1'b1);
        step(1'b1, 1'b0, 0, 1'b0, 1'b1);
        #12 chk("abort_count", bus.instr_count, 32'd0);
        step(1'b0, 1'b1, 0, 1'b0, 1'b1);
        #3 force dut.count = 32'hFFFF_FFFF;
        #1 release dut.count;
        m_cnt = 32'hFFFF_FFFF;
        run(6'b001000, 0, 0, 1'b0);
        #12;
        chk("wrap_count", bus.instr_count, 32'd0);
        chk("addi_len", 32'(last_len), 32'd4);
        e_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
